ray_scheduler: RTL and testbench
================================

RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320; number of ray columns issued per frame.
REQ-002 Parameter POSE_W, default 96; packed pose width, {posX, posY, dirX, dirY, planeX, planeY}, each 16-bit 8.8 fixed point.
REQ-003 pixel_clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 pose_in  input  POSE_W  pose from the player controller.
REQ-006 pose_valid_in  input  1  pose_in valid this cycle; updates the shadow pose.
REQ-007 ray_ready_in  input  1  ray-calculation stage accepts a column this cycle.
REQ-008 render_done_in  input  1  one-cycle pulse: last pixel of the frame has been written to the back buffer.
REQ-009 frame_swap_in  input  1  one-cycle pulse: frame buffer has swapped and the back buffer is free.
REQ-010 ray_valid_out  output  1  hcount_out/pose_out hold a column request.
REQ-011 hcount_out  output  9  column index, 0..SCREEN_WIDTH-1.
REQ-012 pose_out  output  POSE_W  pose for the current frame; constant for the whole frame.
REQ-013 frame_active_out  output  1  high while a frame is being issued or drained.
REQ-014 frame_count_out  output  8  count of completed frames, mod 256.

Function
REQ-015 FSM states: LATCH, ISSUE, DRAIN, WAIT_SWAP; exactly one state is active per cycle.
REQ-016 Shadow pose: loads pose_in on every cycle with pose_valid_in=1, in any state.
REQ-017 LATCH lasts one cycle: pose_out <= pose_in if pose_valid_in=1 that cycle, else shadow; hcount_out <= 0; next state ISSUE.
REQ-018 ISSUE: ray_valid_out=1; a transfer occurs when ray_valid_out and ray_ready_in are both high.
REQ-019 On a transfer with hcount_out < SCREEN_WIDTH-1, hcount_out increments by 1 on the next cycle.
REQ-020 On a transfer with hcount_out = SCREEN_WIDTH-1: next state DRAIN, ray_valid_out=0 next cycle, hcount_out wraps to 0.
REQ-021 While ray_valid_out=1 and ray_ready_in=0, hcount_out and pose_out hold stable; ray_valid_out never drops without a transfer.
REQ-022 DRAIN: wait for render_done_in=1, then go to WAIT_SWAP and increment frame_count_out (255 wraps to 0).
REQ-023 WAIT_SWAP: wait for frame_swap_in=1, then go to LATCH.
REQ-024 render_done_in outside DRAIN and frame_swap_in outside WAIT_SWAP are ignored.
REQ-025 render_done_in and frame_swap_in high together in DRAIN: go to WAIT_SWAP; that swap pulse is ignored.
REQ-026 pose_out changes only on the LATCH cycle; pose_valid_in during ISSUE, DRAIN or WAIT_SWAP affects only the shadow.
REQ-027 frame_active_out=1 in LATCH, ISSUE and DRAIN; 0 in WAIT_SWAP.
REQ-028 Exactly SCREEN_WIDTH transfers per frame, in order 0..SCREEN_WIDTH-1, with no duplicates or gaps.
REQ-029 With ray_ready_in held at 1, first valid occurs 1 cycle after LATCH; all columns are issued in SCREEN_WIDTH consecutive cycles.

Reset
REQ-030 While rst_in=1: state LATCH, ray_valid_out=0, hcount_out=0, frame_count_out=0, frame_active_out=1.
REQ-031 Reset loads shadow and pose_out with DEFAULT_POSE: posX=0x0B80, posY=0x0B80, dirX=0x0100, dirY=0, planeX=0, planeY=0x00A9.
REQ-032 Reset mid-frame abandons the frame without a frame_count increment; the first cycle after reset release is LATCH.

Structure
REQ-033 Shared package raycast_pkg holds SCREEN_WIDTH, the packed pose struct typedef, DEFAULT_POSE, and the scheduler state enum.
REQ-034 Single module, no sub-module; the FSM, shadow register, column counter and frame counter are all local.

Verification
REQ-035 Reset release with ray_ready_in=1: hcount_out 0..319 on cycles 2..321 after release, pose_out=DEFAULT_POSE, then DRAIN.
REQ-036 ray_ready_in toggled pseudo-randomly: exactly 320 transfers in order; no change in hcount_out while stalled.
REQ-037 pose_valid_in with posX=0x0C00 mid-ISSUE: pose_out unchanged this frame; next frame pose_out.posX=0x0C00.
REQ-038 render_done_in pulsed in ISSUE, then frame_swap_in in DRAIN: both ignored; stays in DRAIN until a later render_done_in.
REQ-039 Run 256 frames: frame_count_out increments once per render_done_in in DRAIN and wraps from 255 to 0.
REQ-040 rst_in asserted at hcount_out=150: next cycle ray_valid_out=0, frame_count_out=0; the frame restarts at column 0.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: screen geometry, packed pose layout, reset pose
// and the scheduler state encoding.
package raycast_pkg;

  localparam int unsigned SCREEN_WIDTH = 320;
  localparam int unsigned POSE_W       = 96;
  localparam int unsigned HCOUNT_W     = 9;

  // Each field is 8.8 fixed point; pos_x lands in the most significant bits.
  typedef struct packed {
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] dir_x;
    logic [15:0] dir_y;
    logic [15:0] plane_x;
    logic [15:0] plane_y;
  } pose_t;

  localparam pose_t DEFAULT_POSE = '{
    pos_x:   16'h0B80,
    pos_y:   16'h0B80,
    dir_x:   16'h0100,
    dir_y:   16'h0000,
    plane_x: 16'h0000,
    plane_y: 16'h00A9
  };

  typedef enum logic [1:0] {
    StLatch,
    StIssue,
    StDrain,
    StWaitSwap
  } sched_state_e;

endpackage

// File: rtl/ray_scheduler_if.sv
// Column-request bus between the scheduler and the ray-calculation stage.
//   ray_valid_out : a column request is held on hcount_out/pose_out
//   ray_ready_in  : the ray stage accepts the request this cycle
//   hcount_out    : column index
//   pose_out      : pose for the whole frame
// master = scheduler side, slave = ray-calculation side.
interface ray_scheduler_if #(
  parameter int unsigned POSE_W = raycast_pkg::POSE_W
) ();

  logic              ray_valid_out;
  logic              ray_ready_in;
  logic [8:0]        hcount_out;
  logic [POSE_W-1:0] pose_out;

  modport master (
    output ray_valid_out,
    output hcount_out,
    output pose_out,
    input  ray_ready_in
  );

  modport slave (
    input  ray_valid_out,
    input  hcount_out,
    input  pose_out,
    output ray_ready_in
  );

endinterface

// File: rtl/ray_scheduler.sv
// Frame scheduler for the raycaster. Latches one pose per frame, issues every
// column index once through a valid/ready bus, waits for the renderer to finish
// and for the frame buffer to swap, then starts the next frame.
//   pixel_clk_in     : clock, rising edge
//   rst_in           : synchronous active-high reset
//   pose_in          : pose from the player controller
//   pose_valid_in    : pose_in valid, loads the shadow pose
//   render_done_in   : pulse, last pixel of the frame written
//   frame_swap_in    : pulse, buffers swapped and back buffer free
//   frame_active_out : high while a frame is issued or drained
//   frame_count_out  : completed frames, mod 256
//   ray_bus          : column request bus (master side)
module ray_scheduler #(
  parameter int unsigned SCREEN_WIDTH = raycast_pkg::SCREEN_WIDTH,
  parameter int unsigned POSE_W       = raycast_pkg::POSE_W
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [POSE_W-1:0] pose_in,
  input  logic              pose_valid_in,
  input  logic              render_done_in,
  input  logic              frame_swap_in,
  output logic              frame_active_out,
  output logic [7:0]        frame_count_out,
  ray_scheduler_if.master   ray_bus
);

  import raycast_pkg::*;

  localparam logic [8:0] LastCol = 9'(SCREEN_WIDTH - 1);

  sched_state_e      state_q, state_d;
  logic [8:0]        hcount_q, hcount_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic [POSE_W-1:0] shadow_q, shadow_d;
  logic [POSE_W-1:0] pose_q, pose_d;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q       <= StLatch;
      hcount_q      <= '0;
      frame_count_q <= '0;
      shadow_q      <= DEFAULT_POSE;
      pose_q        <= DEFAULT_POSE;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      frame_count_q <= frame_count_d;
      shadow_q      <= shadow_d;
      pose_q        <= pose_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    frame_count_d = frame_count_q;
    pose_d        = pose_q;
    // The shadow tracks the controller in every state.
    shadow_d      = pose_valid_in ? pose_in : shadow_q;

    unique case (state_q)
      StLatch: begin
        // A pose arriving on the latch cycle itself wins over the shadow.
        pose_d   = pose_valid_in ? pose_in : shadow_q;
        hcount_d = '0;
        state_d  = StIssue;
      end
      StIssue: begin
        if (ray_bus.ray_ready_in) begin
          if (hcount_q == LastCol) begin
            hcount_d = '0;
            state_d  = StDrain;
          end else begin
            hcount_d = hcount_q + 9'd1;
          end
        end
      end
      StDrain: begin
        // A swap pulse coincident with render_done is deliberately dropped.
        if (render_done_in) begin
          frame_count_d = frame_count_q + 8'd1;
          state_d       = StWaitSwap;
        end
      end
      StWaitSwap: begin
        if (frame_swap_in) begin
          state_d = StLatch;
        end
      end
      default: state_d = StLatch;
    endcase
  end

  assign ray_bus.ray_valid_out = (state_q == StIssue);
  assign ray_bus.hcount_out    = hcount_q;
  assign ray_bus.pose_out      = pose_q;
  assign frame_active_out      = (state_q != StWaitSwap);
  assign frame_count_out       = frame_count_q;

endmodule

// File: tb/tb_ray_scheduler.sv
module tb_ray_scheduler;

  localparam int SW = 320;
  localparam int WRAP_SW = 4;

  typedef struct {
    logic [8:0]  h;
    logic [95:0] pose;
  } exp_t;

  logic        pixel_clk = 1'b0;
  logic        rst_in;
  logic [95:0] pose_in;
  logic        pose_valid_in;
  logic        render_done_in;
  logic        frame_swap_in;
  logic        frame_active_out;
  logic [7:0]  frame_count_out;

  logic        rst_w;
  logic        w_active;
  logic [7:0]  w_count;

  ray_scheduler_if #(.POSE_W(96)) bus ();
  ray_scheduler_if #(.POSE_W(96)) wbus ();

  ray_scheduler #(.SCREEN_WIDTH(SW), .POSE_W(96)) dut (
    .pixel_clk_in     (pixel_clk),
    .rst_in           (rst_in),
    .pose_in          (pose_in),
    .pose_valid_in    (pose_valid_in),
    .render_done_in   (render_done_in),
    .frame_swap_in    (frame_swap_in),
    .frame_active_out (frame_active_out),
    .frame_count_out  (frame_count_out),
    .ray_bus          (bus)
  );

  // Narrow instance so a full 256-frame wrap fits in a short run.
  ray_scheduler #(.SCREEN_WIDTH(WRAP_SW), .POSE_W(96)) dut_wrap (
    .pixel_clk_in     (pixel_clk),
    .rst_in           (rst_w),
    .pose_in          (96'h0),
    .pose_valid_in    (1'b0),
    .render_done_in   (1'b1),
    .frame_swap_in    (1'b1),
    .frame_active_out (w_active),
    .frame_count_out  (w_count),
    .ray_bus          (wbus)
  );

  assign wbus.ray_ready_in = 1'b1;

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  logic [95:0] def_pose;
  logic [95:0] m_shadow;
  int          m_count;

  task automatic check(input bit ok, input string name, input logic [95:0] act,
                       input logic [95:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted column must be the next expected one,
  // and a stalled request must stay put.
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_h;
  logic [95:0] prev_pose;

  always @(negedge pixel_clk) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check(bus.ray_valid_out == 1'b1, "stall_valid", 96'(bus.ray_valid_out), 96'd1);
        check(bus.hcount_out == prev_h, "stall_hcount", 96'(bus.hcount_out), 96'(prev_h));
        check(bus.pose_out == prev_pose, "stall_pose", bus.pose_out, prev_pose);
      end
      if (bus.ray_valid_out && bus.ray_ready_in) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_transfer", 96'(bus.hcount_out), 96'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(bus.hcount_out == e.h, "col_hcount", 96'(bus.hcount_out), 96'(e.h));
          check(bus.pose_out == e.pose, "col_pose", bus.pose_out, e.pose);
        end
      end
      prev_stall = bus.ray_valid_out && !bus.ray_ready_in;
      prev_h     = bus.hcount_out;
      prev_pose  = bus.pose_out;
    end
  end

  function automatic logic pick_ready(input bit rand_ready);
    return rand_ready ? logic'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Entered and left in the latch cycle of a frame.
  task automatic run_frame(input bit rand_ready, input bit pose_upd, input bit stray,
                           input bit both_in_drain);
    int iter;
    check(frame_active_out == 1'b1, "latch_active", 96'(frame_active_out), 96'd1);
    check(bus.ray_valid_out == 1'b0, "latch_valid", 96'(bus.ray_valid_out), 96'd0);
    for (int c = 0; c < SW; c++) exp_q.push_back('{h: 9'(c), pose: m_shadow});
    bus.ray_ready_in = pick_ready(rand_ready);
    iter = 0;
    while (exp_q.size() != 0 && iter < 5000) begin
      step();
      iter++;
      bus.ray_ready_in = pick_ready(rand_ready);
      pose_valid_in  = 1'b0;
      render_done_in = 1'b0;
      frame_swap_in  = 1'b0;
      if (pose_upd && iter == 100) begin
        pose_in = {16'h0C00, 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom)};
        pose_valid_in = 1'b1;
        m_shadow = pose_in;
      end
      if (stray && iter == 50) render_done_in = 1'b1;
      if (stray && iter == 60) frame_swap_in = 1'b1;
    end
    if (exp_q.size() != 0) begin
      check(1'b0, "issue_timeout", 96'(exp_q.size()), 96'd0);
      exp_q.delete();
    end
    if (!rand_ready) check(iter == SW + 1, "full_rate_cycles", 96'(iter), 96'(SW + 1));
    // Now draining.
    bus.ray_ready_in = 1'b0;
    check(bus.ray_valid_out == 1'b0, "drain_valid", 96'(bus.ray_valid_out), 96'd0);
    check(frame_active_out == 1'b1, "drain_active", 96'(frame_active_out), 96'd1);
    check(frame_count_out == 8'(m_count), "drain_count", 96'(frame_count_out), 96'(m_count));
    if (stray) begin
      frame_swap_in = 1'b1;
      step();
      frame_swap_in = 1'b0;
      step();
      step();
      check(frame_active_out == 1'b1, "drain_hold", 96'(frame_active_out), 96'd1);
      check(frame_count_out == 8'(m_count), "drain_hold_count", 96'(frame_count_out),
            96'(m_count));
    end
    render_done_in = 1'b1;
    frame_swap_in  = both_in_drain;
    step();
    render_done_in = 1'b0;
    frame_swap_in  = 1'b0;
    m_count = (m_count + 1) % 256;
    check(frame_count_out == 8'(m_count), "frame_count", 96'(frame_count_out), 96'(m_count));
    check(frame_active_out == 1'b0, "wait_active", 96'(frame_active_out), 96'd0);
    if (both_in_drain) begin
      step();
      check(frame_active_out == 1'b0, "swap_ignored", 96'(frame_active_out), 96'd0);
    end
    frame_swap_in = 1'b1;
    step();
    frame_swap_in = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check(bus.ray_valid_out == 1'b0, {tag, "_valid"}, 96'(bus.ray_valid_out), 96'd0);
    check(bus.hcount_out == 9'd0, {tag, "_hcount"}, 96'(bus.hcount_out), 96'd0);
    check(frame_count_out == 8'd0, {tag, "_count"}, 96'(frame_count_out), 96'd0);
    check(frame_active_out == 1'b1, {tag, "_active"}, 96'(frame_active_out), 96'd1);
    check(bus.pose_out == def_pose, {tag, "_pose"}, bus.pose_out, def_pose);
  endtask

  initial begin
    def_pose = {16'h0B80, 16'h0B80, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};
    rst_in = 1'b1;
    rst_w = 1'b1;
    pose_in = '0;
    pose_valid_in = 1'b0;
    render_done_in = 1'b0;
    frame_swap_in = 1'b0;
    bus.ray_ready_in = 1'b1;
    repeat (3) step();
    check_reset_state("reset");
    m_shadow = def_pose;
    m_count = 0;
    rst_in = 1'b0;

    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b1, 1'b0, f[0]);

    // Reset while column 150 is on the bus.
    for (int c = 0; c < SW; c++) exp_q.push_back('{h: 9'(c), pose: m_shadow});
    bus.ray_ready_in = 1'b1;
    for (int i = 0; i < 151; i++) step();
    rst_in = 1'b1;
    step();
    check_reset_state("midreset");
    exp_q.delete();
    m_shadow = def_pose;
    m_count = 0;
    rst_in = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Park the main instance; exercise the 8-bit wrap on the narrow one.
    rst_in = 1'b1;
    bus.ray_ready_in = 1'b0;
    step();
    rst_w = 1'b0;
    // With done/swap held high each frame lasts WRAP_SW + 3 cycles.
    for (int i = 0; i < WRAP_SW + 2; i++) step();
    for (int k = 0; k < 260; k++) begin
      check(w_count == 8'((k + 1) % 256), "wrap_count", 96'(w_count), 96'((k + 1) % 256));
      check(w_active == 1'b0, "wrap_wait_active", 96'(w_active), 96'd0);
      for (int i = 0; i < WRAP_SW + 3; i++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
